// File: rtl/picorv32_mem_stall.sv
// Wait-state injector between the picorv32 native memory port and a bench RAM.
// Holds one request, stalls N cycles (fixed or LFSR), issues it, and returns a one-cycle ready.
module picorv32_mem_stall #(
  parameter int          MAX_WAIT_LOG2 = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_random,
  input  logic [3:0]  cfg_wait,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_valid,
  output logic        ram_instr,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic [31:0] txn_count,
  output logic [31:0] stall_count,
  output logic        proto_err
);
  localparam int CW = (MAX_WAIT_LOG2 > 4) ? MAX_WAIT_LOG2 : 4;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ISSUE, ST_RESP} state_t;

  state_t        state_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] wcnt_q, wait_n;
  logic          mem_ready_q;
  logic [31:0]   mem_rdata_q;
  logic          ram_valid_q, ram_instr_q;
  logic [31:0]   ram_addr_q, ram_wdata_q;
  logic [3:0]    ram_wstrb_q;
  logic [31:0]   txn_q, stall_q, stall_d;
  logic          perr_q, perr_d;
  logic          hold_bad, stray_ready;

  always_comb begin
    lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    wait_n      = cfg_random ? CW'(lfsr_q[MAX_WAIT_LOG2-1:0]) : CW'(cfg_wait);
    // Core must hold its request stable until it sees mem_ready.
    hold_bad    = (state_q == ST_WAIT || state_q == ST_ISSUE) &&
                  (!mem_valid || mem_addr != ram_addr_q ||
                   mem_wdata != ram_wdata_q || mem_wstrb != ram_wstrb_q);
    stray_ready = ram_ready && (state_q != ST_ISSUE);
    perr_d      = perr_q | hold_bad | stray_ready;
    stall_d     = (mem_valid && !mem_ready_q) ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= LFSR_SEED;
      wcnt_q      <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      ram_valid_q <= 1'b0;
      ram_instr_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wstrb_q <= '0;
      txn_q       <= '0;
      stall_q     <= '0;
      perr_q      <= 1'b0;
    end else begin
      stall_q <= stall_d;
      perr_q  <= perr_d;
      case (state_q)
        ST_IDLE: begin
          if (mem_valid) begin
            ram_instr_q <= mem_instr;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
            ram_wstrb_q <= mem_wstrb;
            lfsr_q      <= lfsr_d;
            wcnt_q      <= wait_n;
            if (wait_n == '0) begin
              state_q     <= ST_ISSUE;
              ram_valid_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wcnt_q == CW'(1)) begin
            state_q     <= ST_ISSUE;
            ram_valid_q <= 1'b1;
          end
          wcnt_q <= wcnt_q - CW'(1);
        end
        ST_ISSUE: begin
          if (ram_ready) begin
            ram_valid_q <= 1'b0;
            mem_ready_q <= 1'b1;
            txn_q       <= txn_q + 32'd1;
            state_q     <= ST_RESP;
            if (ram_wstrb_q == 4'b0000) mem_rdata_q <= ram_rdata;
          end
        end
        ST_RESP: begin
          mem_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_ready   = mem_ready_q;
  assign mem_rdata   = mem_rdata_q;
  assign ram_valid   = ram_valid_q;
  assign ram_instr   = ram_instr_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_wstrb   = ram_wstrb_q;
  assign txn_count   = txn_q;
  assign stall_count = stall_q;
  assign proto_err   = perr_q;

endmodule

// File: tb/tb_picorv32_mem_stall.sv
// Directed bench for picorv32_mem_stall: vector table of single transactions plus
// hand sequences for random waits, hold violations, stray ready and mid-transaction reset.
module tb_picorv32_mem_stall;
  logic        clk = 1'b0;
  logic        reset, cfg_random;
  logic [3:0]  cfg_wait;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_valid, ram_instr;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        ram_ready;
  logic [31:0] ram_rdata;
  logic [31:0] txn_count, stall_count;
  logic        proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  // RAM model: ready on the ram_lat-th cycle of ram_valid (1 = combinational)
  int          ram_lat = 1;
  int          vcnt    = 0;
  logic        ram_inj = 1'b0;
  logic [31:0] ram [0:255];
  bit          ram_init_done = 1'b0;

  always #5 clk = ~clk;

  picorv32_mem_stall #(.MAX_WAIT_LOG2(3), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .cfg_random(cfg_random), .cfg_wait(cfg_wait),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .ram_valid(ram_valid), .ram_instr(ram_instr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_ready(ram_ready), .ram_rdata(ram_rdata), .txn_count(txn_count),
    .stall_count(stall_count), .proto_err(proto_err)
  );

  assign ram_ready = (ram_valid && (vcnt == ram_lat - 1)) || ram_inj;
  assign ram_rdata = ram[ram_addr[9:2]];

  always @(posedge clk) begin
    vcnt <= (ram_valid && !ram_ready) ? vcnt + 1 : 0;
    if (!ram_init_done) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h1000_0000 + 32'(i);
      ram[64] <= 32'hDEADBEEF;
      ram[65] <= 32'hCAFEF00D;
      ram[66] <= 32'h0BADC0DE;
      ram[67] <= 32'h55AA33CC;
      ram_init_done <= 1'b1;
    end else if (ram_valid && ram_ready) begin
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Issue one request in an IDLE cycle; returns cycle offsets (accept cycle = 0).
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         output int t_valid, output int t_ready, output int v_cycles,
                         output logic [31:0] cap_addr, output logic [3:0] cap_wstrb,
                         output logic cap_instr);
    mem_valid = 1'b1;
    mem_instr = (ws == 4'b0000);
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    t_valid = -1; t_ready = -1; v_cycles = 0;
    cap_addr = '0; cap_wstrb = '0; cap_instr = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) cfg_wait = ~cfg_wait;
      if (ram_valid) begin
        v_cycles++;
        if (t_valid < 0) begin
          t_valid = cyc; cap_addr = ram_addr; cap_wstrb = ram_wstrb; cap_instr = ram_instr;
        end
      end
      if (mem_ready) begin
        t_ready = cyc;
        break;
      end
    end
    mem_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  wt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] exp_rdata;
    int          exp_valid;
    int          exp_ready;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int          tv, tr, vc;
    logic [31:0] ca;
    logic [3:0]  cw;
    logic        ci;
    logic [31:0] s0, t0;
    logic [15:0] model;
    int          n;
    bit          seen;

    vecs[0] = '{4'd0,  32'h100, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 1,  2};
    vecs[1] = '{4'd5,  32'h104, 32'h12345678, 4'b0011, 1, 32'hDEADBEEF, 6,  7};
    vecs[2] = '{4'd2,  32'h104, 32'h0,        4'b0000, 1, 32'hCAFE5678, 3,  4};
    vecs[3] = '{4'd1,  32'h108, 32'h0,        4'b0000, 3, 32'h0BADC0DE, 2,  5};
    vecs[4] = '{4'd15, 32'h10C, 32'h0,        4'b0000, 2, 32'h55AA33CC, 16, 18};

    reset = 1'b1; cfg_random = 1'b0; cfg_wait = 4'd0;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_ram_valid", 32'(ram_valid), 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wstrb", 32'(ram_wstrb), 32'd0);
    chk("rst_txn", txn_count, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    chk("rst_proto", 32'(proto_err), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cfg_random = 1'b0;
      cfg_wait   = vecs[i].wt;
      ram_lat    = vecs[i].lat;
      s0 = stall_count; t0 = txn_count;
      run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, tv, tr, vc, ca, cw, ci);
      chk($sformatf("v%0d_valid_rise", i), 32'(tv), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_ready_at", i), 32'(tr), 32'(vecs[i].exp_ready));
      chk($sformatf("v%0d_valid_cycles", i), 32'(vc), 32'(vecs[i].lat));
      chk($sformatf("v%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_ram_addr", i), ca, vecs[i].addr);
      chk($sformatf("v%0d_ram_wstrb", i), 32'(cw), 32'(vecs[i].wstrb));
      chk($sformatf("v%0d_ram_instr", i), 32'(ci), 32'(vecs[i].wstrb == 4'b0000));
      chk($sformatf("v%0d_stall_delta", i), stall_count - s0, 32'(vecs[i].exp_ready));
      chk($sformatf("v%0d_txn_delta", i), txn_count - t0, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_single", i), 32'(mem_ready), 32'd0);
    end
    chk("vec_proto", 32'(proto_err), 32'd0);

    // random waits against a reference LFSR from the seed
    do_reset();
    model = 16'hACE1; cfg_random = 1'b1; ram_lat = 1;
    for (int i = 0; i < 8; i++) begin
      n = int'(model[2:0]);
      model = lfsr_step(model);
      run_txn(32'h200 + 32'(4*i), 32'h0, 4'b0000, tv, tr, vc, ca, cw, ci);
      chk($sformatf("rnd%0d_valid_rise", i), 32'(tv), 32'(n + 1));
      chk($sformatf("rnd%0d_ready_at", i), 32'(tr), 32'(n + 2));
      chk($sformatf("rnd%0d_rdata", i), mem_rdata, 32'h1000_0080 + 32'(i));
      @(posedge clk); #1;
    end
    chk("rnd_txn_count", txn_count, 32'd8);
    chk("rnd_proto", 32'(proto_err), 32'd0);

    // core moves its address while the request is stalled
    do_reset();
    cfg_random = 1'b0; cfg_wait = 4'd3; ram_lat = 1;
    mem_valid = 1'b1; mem_addr = 32'h100; mem_wdata = '0; mem_wstrb = '0;
    @(posedge clk); #1;
    chk("hold_proto_before", 32'(proto_err), 32'd0);
    mem_addr = 32'h104;
    ca = '0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ram_valid) ca = ram_addr;
      if (mem_ready) begin seen = 1'b1; break; end
    end
    mem_valid = 1'b0;
    chk("hold_completed", 32'(seen), 32'd1);
    chk("hold_ram_addr", ca, 32'h100);
    chk("hold_rdata", mem_rdata, 32'hDEADBEEF);
    chk("hold_proto_set", 32'(proto_err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_proto_sticky", 32'(proto_err), 32'd1);

    // ram_ready while idle
    do_reset();
    chk("stray_proto_clr", 32'(proto_err), 32'd0);
    ram_inj = 1'b1;
    @(posedge clk); #1;
    ram_inj = 1'b0;
    chk("stray_proto_set", 32'(proto_err), 32'd1);
    chk("stray_no_ready", 32'(mem_ready), 32'd0);

    // reset while the request sits in ISSUE
    do_reset();
    cfg_random = 1'b0; cfg_wait = 4'd0; ram_lat = 3;
    mem_valid = 1'b1; mem_addr = 32'h108; mem_wstrb = '0;
    @(posedge clk); #1;
    chk("rstiss_in_issue", 32'(ram_valid), 32'd1);
    reset = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstiss_ram_valid", 32'(ram_valid), 32'd0);
    chk("rstiss_txn", txn_count, 32'd0);
    chk("rstiss_stall", stall_count, 32'd0);
    seen = mem_ready;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | mem_ready;
    end
    chk("rstiss_no_ready", 32'(seen), 32'd0);
    cfg_random = 1'b1; ram_lat = 1;
    run_txn(32'h100, 32'h0, 4'b0000, tv, tr, vc, ca, cw, ci);
    chk("rstiss_seed_wait", 32'(tv), 32'd2);
    chk("rstiss_ready_at", 32'(tr), 32'd3);
    chk("rstiss_rdata", mem_rdata, 32'hDEADBEEF);
    chk("rstiss_txn_after", txn_count, 32'd1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/picorv32_mem_stall.md
Name: picorv32_mem_stall

Overview:
- Sits between the picorv32 native memory interface and a simple single-port RAM model in simulation benches.
- Accepts one core request at a time, inserts a programmable or pseudo-random number of wait states, then forwards the request to the RAM and returns the response with a one-cycle mem_ready pulse.
- Exercises core stall paths and counts transactions and stall cycles.
- Flags violations of the core's request-hold rule.

Parameters:
- MAX_WAIT_LOG2, 3, width of the random wait field; random waits range 0..2^MAX_WAIT_LOG2-1.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_random  in  1  1 = wait count from LFSR, 0 = wait count from cfg_wait; sampled at request accept.
- cfg_wait  in  4  fixed wait-state count when cfg_random=0.
- mem_valid  in  1  core request valid.
- mem_instr  in  1  core instruction-fetch qualifier; captured, forwarded.
- mem_addr  in  32  core address.
- mem_wdata  in  32  core write data.
- mem_wstrb  in  4  core byte strobes; 0 = read.
- mem_ready  out  1  one-cycle response pulse to core.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- ram_valid  out  1  request to RAM.
- ram_instr  out  1  captured mem_instr.
- ram_addr  out  32  captured address.
- ram_wdata  out  32  captured write data.
- ram_wstrb  out  4  captured strobes.
- ram_ready  in  1  RAM completion; may be combinational or delayed.
- ram_rdata  in  32  RAM read data, valid with ram_ready.
- txn_count  out  32  completed transactions.
- stall_count  out  32  cycles with mem_valid=1 and mem_ready=0.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values, all outputs: mem_ready=0, mem_rdata=0, ram_valid=0, ram_* captured fields=0, txn_count=0, stall_count=0, proto_err=0. LFSR=LFSR_SEED, state=IDLE.
- Reset mid-transaction: state returns to IDLE and ram_valid drops next cycle. No mem_ready is generated for the aborted request.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances exactly once per accepted request (whether or not cfg_random is set).
  - Random wait N = LFSR[MAX_WAIT_LOG2-1:0], taken before the advance.
  - Fixed mode: N = cfg_wait.
- IDLE:
  - If mem_valid=1: capture instr/addr/wdata/wstrb into ram_* and load the wait counter with N.
  - Next state: WAIT if N>0, else ISSUE.
- WAIT: the counter decrements each cycle. State moves to ISSUE on the edge where the counter reaches 1, so exactly N cycles are spent in WAIT.
- ISSUE:
  - ram_valid=1 (registered, asserted for the whole state).
  - On an edge with ram_ready=1: latch ram_rdata into mem_rdata (reads only; writes leave mem_rdata unchanged) and go to RESP.
  - ram_valid deasserts on that same edge.
- RESP:
  - mem_ready=1 for exactly one cycle, txn_count increments, then go to IDLE.
  - A mem_valid that is high in the IDLE cycle after RESP is treated as a new request.
- Latency: with a combinational-ready RAM, mem_ready is high in the cycle N+2 cycles after the edge where the request was accepted.
- stall_count: increments each cycle with mem_valid=1 and mem_ready=0, in any state, including the accept cycle. Both counters wrap modulo 2^32.
- proto_err is set and held until reset in either case:
  - In WAIT/ISSUE, mem_valid drops, or mem_addr/mem_wdata/mem_wstrb differ from the captured values.
  - ram_ready=1 while not in ISSUE (ignored otherwise).
  - The transaction still completes using the captured values.
- cfg_random/cfg_wait changes during a transaction do not affect it.

Test Plan:
- cfg_random=0, cfg_wait=0, combinational RAM, read at 0x100 with RAM word 0xDEADBEEF:
  - mem_ready pulses 2 cycles after accept with mem_rdata=0xDEADBEEF.
  - txn_count=1, stall_count=2.
- cfg_wait=5, write 0x12345678 with wstrb=4'b0011:
  - ram_valid rises 6 cycles after accept with ram_wstrb=0011.
  - mem_ready 1 cycle after ram_ready; stall_count=7.
- cfg_random=1, MAX_WAIT_LOG2=3, seed 0xACE1, 8 back-to-back reads: per-request wait counts match a reference LFSR model, each in 0..7; txn_count=8.
- RAM with 3-cycle registered ready: ram_valid held for 3 cycles; exactly one mem_ready pulse; proto_err=0.
- Core changes mem_addr from 0x100 to 0x104 during WAIT: proto_err=1 and stays 1; RAM is still accessed at 0x100.
- reset asserted during ISSUE: next cycle ram_valid=0, counters=0, no mem_ready. A following request completes normally and uses LFSR_SEED for its wait.
